exc_int_controller: RTL

Exception and interrupt arbitration stage sitting directly upstream of the CP0 register file. Each cycle it combines hardware interrupt lines, the exception report from the commit stage, `eret` and `mtc0` requests with current SR/Cause/EPC values. It produces the per-register write data and enables consumed by CP0, the EPC/Cause/SR update for exception entry, and a registered one-cycle PC redirect plus flush toward fetch.

---
 rtl/exc_int_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/exc_int_controller.sv
// ============================================================================
// Module  : exc_int_controller
// Purpose : Exception/interrupt arbitration ahead of CP0. Builds CP0 write
//           ports and a registered one-cycle fetch redirect with flush.
//           Define EXC_INT_SYNC_EN to pass hw_int through a 2-flop synchronizer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exc_int_controller #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          HW_INT_W     = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                exc_valid,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                exc_bd,
    input  logic                eret,
    input  logic                mtc0_en,
    input  logic [4:0]          mtc0_addr,
    input  logic [31:0]         mtc0_data,
    input  logic [31:0]         SR_value,
    input  logic [31:0]         Cause_value,
    input  logic [31:0]         EPC_value,
    output logic [31:0]         SR_input,
    output logic                SR_enable,
    output logic [31:0]         Cause_input,
    output logic                Cause_enable,
    output logic [31:0]         EPC_input,
    output logic                EPC_enable,
    output logic                flush,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                int_pending
);

    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [31:0]         r_redirect_pc;
    logic [31:0]         w_next_pc;
    logic                w_load_pc;
    logic                w_flush;
    logic                w_entry;
    logic                w_pending;
    logic [HW_INT_W-1:0] w_ip;

`ifdef EXC_INT_SYNC_EN
    logic [HW_INT_W-1:0] r_sync1;
    logic [HW_INT_W-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= hw_int;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ip = r_sync2;
`else
    assign w_ip = hw_int;
`endif

    assign w_pending = SR_value[0] & ~SR_value[1] & (|(w_ip & SR_value[10 +: HW_INT_W]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_pc) begin
                r_redirect_pc <= w_next_pc;
            end
        end
    end

    always_comb begin
        SR_input     = SR_value;
        SR_enable    = 1'b0;
        Cause_input  = Cause_value;
        Cause_enable = 1'b0;
        EPC_input    = EPC_value;
        EPC_enable   = 1'b0;
        w_flush      = 1'b0;
        w_entry      = 1'b0;
        w_load_pc    = 1'b0;
        w_next_pc    = r_redirect_pc;
        w_next_state = ST_RUN;

        if (reset) begin
            if (r_state == ST_RUN) begin
                // Interrupt outranks the exception; both share the entry path.
                if (w_pending || exc_valid) begin
                    w_entry      = 1'b1;
                    EPC_input    = (exc_pc & ~32'd3) - (exc_bd ? 32'd4 : 32'd0);
                    Cause_input  = {exc_bd, Cause_value[30:16], w_ip, Cause_value[9:7],
                                    (w_pending ? 5'd0 : exc_code), 2'b00};
                    SR_input     = SR_value | 32'h2;
                    EPC_enable   = 1'b1;
                    Cause_enable = 1'b1;
                    SR_enable    = 1'b1;
                    w_flush      = 1'b1;
                    w_load_pc    = 1'b1;
                    w_next_pc    = HANDLER_ADDR;
                    w_next_state = ST_REDIRECT;
                end else if (eret) begin
                    SR_input     = SR_value & ~32'h2;
                    SR_enable    = 1'b1;
                    w_flush      = 1'b1;
                    w_load_pc    = 1'b1;
                    w_next_pc    = EPC_value;
                    w_next_state = ST_REDIRECT;
                end else if (mtc0_en) begin
                    case (mtc0_addr)
                        c_ADDR_SR: begin
                            SR_input  = mtc0_data;
                            SR_enable = 1'b1;
                        end
                        c_ADDR_CAUSE: begin
                            Cause_input[9:8] = mtc0_data[9:8];
                            Cause_enable     = 1'b1;
                        end
                        c_ADDR_EPC: begin
                            EPC_input  = mtc0_data;
                            EPC_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            // IP mirroring merges with any software Cause write already staged.
            if (!w_entry && (w_ip != Cause_value[10 +: HW_INT_W])) begin
                Cause_input[10 +: HW_INT_W] = w_ip;
                Cause_enable                = 1'b1;
            end
        end
    end

    assign redirect_valid = (r_state == ST_REDIRECT);
    assign flush          = w_flush | redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign int_pending    = reset & w_pending;

endmodule

`default_nettype wire
